// File: rtl/cubev_dbus_resp.sv
`default_nettype none
// cubev_dbus_resp: CUBEV dbus responder with scratch RAM, LIFO at address 0 and test-status register.
// Stack enabled by CUBEV_DBUS_STACK_EN; otherwise address 0 is plain RAM. Rev 1.0
module cubev_dbus_resp #(
    parameter int          MEM_AW      = 16,
    parameter int          STACK_DEPTH = 16,
    parameter logic [31:0] STATUS_ADD  = 32'h1001200C
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [5:0]  thread_pipe_valid,
    input  logic [31:0] dbus_rdwr_add,
    input  logic [1:0]  dbus_rdwr_width,
    input  logic        dbus_rd_i_req,
    input  logic [31:0] dbus_wr_data,
    input  logic        dbus_wr_en,
    output logic [31:0] dbus_rd_i_data,
    output logic [1:0]  pass_cnt,
    output logic        test_done,
    output logic        test_fail,
    output logic        stack_err
);

    localparam int          BANK_AW    = MEM_AW - 2;
    localparam int          BANK_WORDS = 1 << BANK_AW;
    localparam logic [31:0] PASS_CODE  = 32'h00400000;
    localparam logic [31:0] FAIL_CODE  = 32'h00080000;

    logic [31:0] add2, add3;
    logic [31:0] wr_data2, wr_data3;
    logic [1:0]  width2, width3;
    logic        rd_req2, rd_req3;
    logic        wr_en3;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            add2     <= '0;
            width2   <= '0;
            rd_req2  <= 1'b0;
            wr_data2 <= '0;
            add3     <= '0;
            width3   <= '0;
            rd_req3  <= 1'b0;
            wr_data3 <= '0;
            wr_en3   <= 1'b0;
        end else begin
            add2     <= dbus_rdwr_add;
            width2   <= dbus_rdwr_width;
            rd_req2  <= dbus_rd_i_req;
            wr_data2 <= dbus_wr_data;
            add3     <= add2;
            width3   <= width2;
            rd_req3  <= rd_req2;
            wr_data3 <= wr_data2;
            wr_en3   <= dbus_wr_en;
        end
    end

    logic        commit;
    logic        sel_stack;
    logic        sel_status;
    logic        sel_ram;
    logic [31:0] stack_top;

    assign commit     = (thread_pipe_valid == 6'h01);
    assign sel_status = !sel_stack && (add3 == STATUS_ADD);
    assign sel_ram    = !sel_stack && !sel_status;

    logic [3:0]  byte_en;
    logic        ram_we;
    logic [7:0]  lane_rdata [4];
    logic [31:0] ram_rdata;

    assign byte_en = {width3[1], width3[1], (width3 != 2'd0), 1'b1};
    assign ram_we  = commit && wr_en3 && sel_ram;

    for (genvar k = 0; k < 4; k++) begin : g_lane
        logic [7:0]         bank [BANK_WORDS];
        logic [1:0]         offs;
        logic               wrap;
        logic [BANK_AW-1:0] idx;

        // Lanes below the starting lane hold bytes of the following word.
        assign offs = 2'(k) - add3[1:0];
        assign wrap = (2'(k) < add3[1:0]);
        assign idx  = add3[MEM_AW-1:2] + BANK_AW'(wrap);

        always_ff @(posedge clk) begin
            if (ram_we && byte_en[offs]) begin
                bank[idx] <= wr_data3[8*offs +: 8];
            end
        end

        assign lane_rdata[k] = bank[idx];
    end

    always_comb begin
        ram_rdata = '0;
        for (int i = 0; i < 4; i++) begin
            ram_rdata[8*i +: 8] = lane_rdata[2'(add3[1:0] + 2'(i))];
        end
    end

`ifdef CUBEV_DBUS_STACK_EN
    localparam int SP_W = $clog2(STACK_DEPTH) + 1;

    logic [SP_W-1:0] sp;
    logic [SP_W-2:0] sp_idx;
    logic [31:0]     stack_mem [STACK_DEPTH];
    logic            stack_full;
    logic            stack_empty;
    logic            stack_op;

    assign sel_stack   = (add3 == 32'd0);
    assign sp_idx      = sp[SP_W-2:0];
    assign stack_full  = (sp == SP_W'(STACK_DEPTH));
    assign stack_empty = (sp == '0);
    assign stack_op    = commit && sel_stack;
    assign stack_top   = stack_empty ? 32'd0 : stack_mem[sp_idx - 1'b1];

    always_ff @(posedge clk) begin
        if (stack_op && wr_en3 && !stack_full) begin
            stack_mem[sp_idx] <= wr_data3;
        end
    end

    // A simultaneous read and write is treated as a push only.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sp        <= '0;
            stack_err <= 1'b0;
        end else if (stack_op) begin
            if (wr_en3) begin
                if (stack_full) begin
                    stack_err <= 1'b1;
                end else begin
                    sp <= sp + 1'b1;
                end
            end else if (rd_req3) begin
                if (stack_empty) begin
                    stack_err <= 1'b1;
                end else begin
                    sp <= sp - 1'b1;
                end
            end
        end
    end
`else
    logic unused_stack_cfg;

    assign sel_stack        = 1'b0;
    assign stack_top        = 32'd0;
    assign stack_err        = 1'b0;
    assign unused_stack_cfg = rd_req3 | (STACK_DEPTH < 1);
`endif

    logic status_wr;

    assign status_wr = commit && wr_en3 && sel_status;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pass_cnt  <= 2'd0;
            test_fail <= 1'b0;
        end else if (status_wr) begin
            if ((wr_data3 == PASS_CODE) && (pass_cnt != 2'd3)) begin
                pass_cnt <= pass_cnt + 2'd1;
            end
            if (wr_data3 == FAIL_CODE) begin
                test_fail <= 1'b1;
            end
        end
    end

    assign test_done = (pass_cnt == 2'd2);

    always_comb begin
        dbus_rd_i_data = ram_rdata;
        if (sel_stack) begin
            dbus_rd_i_data = stack_top;
        end else if (sel_status) begin
            dbus_rd_i_data = 32'd0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cubev_dbus_resp.sv
`default_nettype none
// tb_cubev_dbus_resp: directed and random dbus traffic checked against a byte/queue reference model.
module tb_cubev_dbus_resp;

    localparam int          MEM_AW   = 16;
    localparam int          DEPTH    = 16;
    localparam logic [31:0] STATUS   = 32'h1001200C;
    localparam logic [31:0] PASS_W   = 32'h00400000;
    localparam logic [31:0] STOP_W   = 32'h00080000;
    localparam int          RAM_SIZE = 1 << MEM_AW;

    typedef struct packed {
        logic [31:0] add;
        logic [1:0]  width;
        logic        rd;
        logic        wr;
        logic [31:0] data;
        logic        commit;
    } txn_t;

    logic        clk;
    logic        rstn;
    logic [5:0]  thread_pipe_valid;
    logic [31:0] dbus_rdwr_add;
    logic [1:0]  dbus_rdwr_width;
    logic        dbus_rd_i_req;
    logic [31:0] dbus_wr_data;
    logic        dbus_wr_en;
    logic [31:0] dbus_rd_i_data;
    logic [1:0]  pass_cnt;
    logic        test_done;
    logic        test_fail;
    logic        stack_err;

    cubev_dbus_resp #(
        .MEM_AW      (MEM_AW),
        .STACK_DEPTH (DEPTH),
        .STATUS_ADD  (STATUS)
    ) dut (
        .clk               (clk),
        .rstn              (rstn),
        .thread_pipe_valid (thread_pipe_valid),
        .dbus_rdwr_add     (dbus_rdwr_add),
        .dbus_rdwr_width   (dbus_rdwr_width),
        .dbus_rd_i_req     (dbus_rd_i_req),
        .dbus_wr_data      (dbus_wr_data),
        .dbus_wr_en        (dbus_wr_en),
        .dbus_rd_i_data    (dbus_rd_i_data),
        .pass_cnt          (pass_cnt),
        .test_done         (test_done),
        .test_fail         (test_fail),
        .stack_err         (stack_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0]  mem_m   [RAM_SIZE];
    bit          known_m [RAM_SIZE];
    logic [31:0] stk [$];
    int          pass_m;
    bit          fail_m;
    bit          err_m;
    txn_t        h0, h1, h2, idle;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic txn_t mk(input logic [31:0] a, input logic [1:0] w, input logic r,
                                input logic wr, input logic [31:0] d, input logic c);
        txn_t t;
        t.add = a; t.width = w; t.rd = r; t.wr = wr; t.data = d; t.commit = c;
        return t;
    endfunction

    // Expected read word plus a mask of the bytes whose value the model knows.
    function automatic void model_read(input logic [31:0] a, output logic [31:0] v,
                                       output logic [31:0] m);
        v = '0;
        m = '1;
`ifdef CUBEV_DBUS_STACK_EN
        if (a == 32'd0) begin
            v = (stk.size() > 0) ? stk[$] : 32'd0;
            return;
        end
`endif
        if (a == STATUS) return;
        for (int i = 0; i < 4; i++) begin
            int idx;
            idx = (int'(a[MEM_AW-1:0]) + i) % RAM_SIZE;
            v[8*i +: 8] = mem_m[idx];
            m[8*i +: 8] = known_m[idx] ? 8'hFF : 8'h00;
        end
    endfunction

    function automatic void model_commit(input txn_t t);
        int n;
        if (!t.commit) return;
`ifdef CUBEV_DBUS_STACK_EN
        if (t.add == 32'd0) begin
            if (t.wr) begin
                if (stk.size() < DEPTH) stk.push_back(t.data);
                else err_m = 1'b1;
            end else if (t.rd) begin
                if (stk.size() > 0) void'(stk.pop_back());
                else err_m = 1'b1;
            end
            return;
        end
`endif
        if (t.add == STATUS) begin
            if (t.wr) begin
                if (t.data == PASS_W && pass_m < 3) pass_m++;
                if (t.data == STOP_W) fail_m = 1'b1;
            end
            return;
        end
        if (!t.wr) return;
        n = (t.width == 2'd0) ? 1 : (t.width == 2'd1) ? 2 : 4;
        for (int i = 0; i < n; i++) begin
            int idx;
            idx = (int'(t.add[MEM_AW-1:0]) + i) % RAM_SIZE;
            mem_m[idx]   = t.data[8*i +: 8];
            known_m[idx] = 1'b1;
        end
    endfunction

    task automatic check_flags();
        chk("pass_cnt",  32'(pass_cnt),  32'(pass_m));
        chk("test_done", 32'(test_done), 32'(pass_m == 2));
        chk("test_fail", 32'(test_fail), 32'(fail_m));
        chk("stack_err", 32'(stack_err), 32'(err_m));
    endtask

    // One bus cycle: issue t, drive wr_en for the previous request, judge the request in stage 3.
    task automatic cycle(input txn_t t);
        logic [31:0] v, m;
        @(posedge clk);
        #1;
        h2 = h1; h1 = h0; h0 = t;
        dbus_rdwr_add     = h0.add;
        dbus_rdwr_width   = h0.width;
        dbus_rd_i_req     = h0.rd;
        dbus_wr_data      = h0.data;
        dbus_wr_en        = h1.wr;
        thread_pipe_valid = h2.commit ? 6'h01 : 6'($urandom_range(2, 63));
        @(negedge clk);
        if (h2.rd) begin
            model_read(h2.add, v, m);
            chk("rd_data", dbus_rd_i_data & m, v & m);
        end
        check_flags();
        model_commit(h2);
    endtask

    task automatic flush();
        cycle(idle);
        cycle(idle);
    endtask

    // mid=1 first moves the newest request into stage 3 with commit asserted, then resets.
    task automatic apply_reset(input bit mid);
        logic [31:0] v, m;
        if (mid) begin
            @(posedge clk);
            #1;
            thread_pipe_valid = 6'h01;
            dbus_wr_en        = 1'b0;
        end
        #1 rstn = 1'b0;
        #1;
        pass_m = 0; fail_m = 1'b0; err_m = 1'b0;
        stk.delete();
        h0 = idle; h1 = idle; h2 = idle;
        model_read(32'd0, v, m);
        chk("rst_rd", dbus_rd_i_data & m, v & m);
        check_flags();
        dbus_rdwr_add = '0; dbus_rdwr_width = '0; dbus_rd_i_req = 1'b0;
        dbus_wr_data = '0; dbus_wr_en = 1'b0; thread_pipe_valid = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    function automatic txn_t rnd_txn();
        txn_t t;
        int   r, d;
        r = int'($urandom_range(0, 99));
        t.width  = 2'($urandom_range(0, 3));
        t.rd     = 1'($urandom_range(0, 1));
        t.wr     = 1'($urandom_range(0, 1));
        t.data   = $urandom;
        t.commit = ($urandom_range(0, 3) != 0);
        if (r < 15) begin
            t.add = 32'd0;
        end else if (r < 25) begin
            t.add = STATUS;
            d = int'($urandom_range(0, 9));
            if (d == 0) t.data = STOP_W;
            else if (d < 5) t.data = PASS_W;
        end else if (r < 85) begin
            t.add = {16'($urandom), 16'h0100 + 16'($urandom_range(0, 63))};
        end else begin
            t.add = {16'($urandom), 16'hFFFC + 16'($urandom_range(0, 3))};
        end
        return t;
    endfunction

    initial begin
        rstn = 1'b1;
        thread_pipe_valid = '0;
        dbus_rdwr_add = '0; dbus_rdwr_width = '0; dbus_rd_i_req = 1'b0;
        dbus_wr_data = '0; dbus_wr_en = 1'b0;
        idle = mk(32'd0, 2'd0, 1'b0, 1'b0, 32'd0, 1'b0);
        h0 = idle; h1 = idle; h2 = idle;
        pass_m = 0; fail_m = 1'b0; err_m = 1'b0;

        apply_reset(1'b0);

        // RAM: aligned word, byte read, misaligned word spanning two words
        cycle(mk(32'h100, 2'd2, 1'b0, 1'b1, 32'hA1B2C3D4, 1'b1));
        cycle(idle);
        cycle(mk(32'h100, 2'd2, 1'b1, 1'b0, 32'd0, 1'b1));
        cycle(mk(32'h102, 2'd0, 1'b1, 1'b0, 32'd0, 1'b1));
        cycle(mk(32'h0FE, 2'd2, 1'b0, 1'b1, 32'h11223344, 1'b1));
        cycle(idle);
        cycle(mk(32'h0FC, 2'd2, 1'b1, 1'b0, 32'd0, 1'b1));
        cycle(mk(32'h100, 2'd2, 1'b1, 1'b0, 32'd0, 1'b1));
        cycle(mk(32'h0FE, 2'd1, 1'b0, 1'b1, 32'hFFFF5566, 1'b1));
        cycle(mk(32'h0FE, 2'd2, 1'b1, 1'b0, 32'd0, 1'b1));
        cycle(mk(32'h0FE, 2'd2, 1'b1, 1'b0, 32'd0, 1'b1));
        flush();

`ifdef CUBEV_DBUS_STACK_EN
        cycle(mk(32'd0, 2'd2, 1'b0, 1'b1, 32'h5, 1'b1));
        cycle(mk(32'd0, 2'd2, 1'b0, 1'b1, 32'h6, 1'b1));
        repeat (3) cycle(mk(32'd0, 2'd2, 1'b1, 1'b0, 32'd0, 1'b1));
        flush();
        apply_reset(1'b0);
        for (int i = 0; i <= DEPTH; i++) cycle(mk(32'd0, 2'd2, 1'b0, 1'b1, 32'h1000 + i, 1'b1));
        for (int i = 0; i <= DEPTH; i++) cycle(mk(32'd0, 2'd2, 1'b1, 1'b0, 32'd0, 1'b1));
        flush();
        apply_reset(1'b0);
`else
        cycle(mk(32'd0, 2'd2, 1'b0, 1'b1, 32'hDEADBEEF, 1'b1));
        cycle(idle);
        cycle(mk(32'd0, 2'd2, 1'b1, 1'b0, 32'd0, 1'b1));
        flush();
`endif

        // Status register: two committed passes, one uncommitted, then fail
        cycle(mk(STATUS, 2'd2, 1'b0, 1'b1, PASS_W, 1'b1));
        cycle(mk(STATUS, 2'd2, 1'b1, 1'b1, PASS_W, 1'b1));
        flush();
        cycle(mk(STATUS, 2'd2, 1'b0, 1'b1, PASS_W, 1'b0));
        cycle(mk(STATUS, 2'd2, 1'b0, 1'b1, 32'h12345678, 1'b1));
        flush();
        cycle(mk(STATUS, 2'd2, 1'b0, 1'b1, STOP_W, 1'b1));
        flush();

        for (int i = 0; i < 400; i++) cycle(rnd_txn());
        flush();

        // Reset with a committed write sitting in stage 3 discards it
        cycle(mk(STATUS, 2'd2, 1'b0, 1'b1, STOP_W, 1'b1));
        cycle(mk(32'h200, 2'd2, 1'b0, 1'b1, 32'h11111111, 1'b1));
        flush();
        cycle(mk(32'h200, 2'd2, 1'b0, 1'b1, 32'h22222222, 1'b1));
        cycle(idle);
        apply_reset(1'b1);
        cycle(mk(32'h200, 2'd2, 1'b1, 1'b0, 32'd0, 1'b1));
        flush();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cubev_dbus_resp.md
# cubev_dbus_resp

Synthesizable data-bus responder for the CUBEV RV32 core. It accepts the core's dbus requests: address, width, read request, write enable and write data. It returns read data through a fixed two-stage pipeline and implements three targets:
- a byte-addressed scratch RAM,
- a LIFO stack port at address 0,
- a test-status register at 0x1001200C (pass/fail signalling).

It sits directly on the core's dbus in place of the behavioural memory model.

## Interface
- MEM_AW, 16: byte-address bits of the RAM window (RAM size 2^MEM_AW bytes)
- STACK_DEPTH, 16: stack entries (32-bit words), power of two
- STATUS_ADD, 32'h1001200C: status register address
- clk  in  1  core clock
- rstn  in  1  asynchronous, active-low reset
- thread_pipe_valid  in  6  commit qualifier; stage-3 side effects only when == 6'h01
- dbus_rdwr_add  in  32  byte address (cycle N)
- dbus_rdwr_width  in  2  0 byte, 1 half, 2/3 word (cycle N)
- dbus_rd_i_req  in  1  read request (cycle N)
- dbus_wr_data  in  32  write data, byte 0 in [7:0] (cycle N)
- dbus_wr_en  in  1  write enable, lags address by one cycle (cycle N+1)
- dbus_rd_i_data  out  32  read data (cycle N+2)
- pass_cnt  out  2  saturating count of pass writes
- test_done  out  1  pass_cnt == 2
- test_fail  out  1  sticky fail flag
- stack_err  out  1  sticky overflow/underflow flag

## Operation
- Stage 2 registers: add, width, rd_req and wr_data from cycle N.
- Stage 3 registers: the stage-2 values, plus dbus_wr_en sampled in cycle N+1.
- All targets act on the stage-3 values.
- Commit = thread_pipe_valid == 6'h01 in the stage-3 cycle.
- Decode priority, first match wins:
  1. add3 == 0 → stack
  2. add3 == STATUS_ADD → status
  3. otherwise → RAM at add3[MEM_AW-1:0] (aliasing)
- RAM organisation:
  - four byte banks; lane k holds bytes with address[1:0] == k
  - access byte i (i = 0..3) maps to address (add3 + i) mod 2^MEM_AW
  - misaligned and word-crossing accesses are fully supported, with no extra cycle
- RAM write on commit & wr_en3:
  - byte 0 always written
  - byte 1 written if width3 != 0
  - bytes 2 and 3 written if width3[1]
- RAM read: always returns the 4 consecutive bytes at add3, regardless of width. The core extracts and sign-extends.
- Stack, with sp ranging 0..STACK_DEPTH:
  - write on commit & wr_en3: push wr_data3, sp+1
  - read on commit & rd_req3: pop, sp-1
  - rd_data = entry[sp-1] (top of stack), or 0 when empty
  - push when full: data dropped, sp unchanged, stack_err set
  - pop when empty: sp stays 0, stack_err set
  - wr_en3 and rd_req3 both active: push only (write priority)
- Status register (write-only; reads return 0), acting on commit & wr_en3:
  - data 32'h00400000 → pass_cnt saturating increment
  - data 32'h00080000 → test_fail set
  - any other data ignored
- No commit: no RAM write, no sp change, no status update. The read data path stays active.
- Reset:
  - clears pipeline registers, sp, pass_cnt, test_done, test_fail and stack_err
  - dbus_rd_i_data reads 0, because add3 = 0 selects the empty stack
  - RAM contents are not reset
  - reset asserted mid-operation aborts any uncommitted stage-3 access

## Timing
- Read latency: 2 cycles. dbus_rd_i_data is combinational from the stage-3 registers and storage, valid throughout cycle N+2.
- Writes commit at the clk edge ending cycle N+2.
- Read-after-write: a read whose stage 3 is cycle N+3 or later sees the new data. A read in the same stage-3 cycle as the write sees the old data.
- Status and stack flags update at the commit edge.
- Back-to-back requests are accepted every cycle; the block never stalls.

## Configuration
- CUBEV_DBUS_STACK_EN defined:
  - stack decoded at address 0 as above
  - stack_err is live
- CUBEV_DBUS_STACK_EN undefined:
  - no stack storage
  - address 0 is ordinary RAM
  - stack_err is tied 0

## Test plan
- Word write 0xA1B2C3D4 to 0x100 (width 2); read 0x100 in a later slot → rd_data 0xA1B2C3D4. Byte read at 0x102 → rd_data[7:0] 0xB2.
- Misaligned word write 0x11223344 to 0x0FE → bytes 0x0FE..0x101 = 44,33,22,11. Word read at 0x0FC returns 0x3344xxxx (old bytes 0x0FC/0x0FD in the low half).
- Push 0x5, 0x6, then two pops at address 0 → 0x6 then 0x5. A third pop → 0 with stack_err = 1. STACK_DEPTH+1 pushes from reset → stack_err = 1 and sp = STACK_DEPTH.
- Write 0x00400000 to 0x1001200C twice with commit → pass_cnt 2, test_done 1. The same write with thread_pipe_valid = 6'h02 → no change.
- Write 0x00080000 to 0x1001200C → test_fail = 1. Assert rstn low mid-sequence → all flags 0 and rd_data 0.
- Build without CUBEV_DBUS_STACK_EN: write 0xDEADBEEF to 0, read 0 → 0xDEADBEEF; stack_err stays 0.
